// File: rtl/circ_smpl_queue.sv
// circ_smpl_queue
// Circular stereo sample queue feeding an FIR band filter. Keeps the most
// recent DEPTH left/right samples. Once the buffer is full, every accepted
// sample triggers a replay of the whole window, oldest to newest, one sample
// per clock while `sequencing` is high.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   lft_smpl   left sample to store (16-bit two's complement)
//   rght_smpl  right sample to store (16-bit two's complement)
//   wrt_smpl   single-cycle write strobe
//   lft_out    left replay data (registered read)
//   rght_out   right replay data (registered read)
//   sequencing replay window active
//   ovr        sticky overrun flag
//
// Build option: define CIRC_QUEUE_OVR_EN to build the sticky overrun flag;
// without it `ovr` is tied low and writes during a replay are still dropped.
module circ_smpl_queue #(
  parameter int DEPTH  = 1021,
  parameter int ADDR_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  input  logic        wrt_smpl,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        sequencing,
  output logic        ovr
);

  // Slot index width; pointers only ever hold 0..DEPTH-1.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  PTR_LAST_C = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST_C = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] RD_LAST_C  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2
  } state_e;

  state_e            state_r, state_nxt_s;
  logic [IDX_W-1:0]  new_ptr_r, new_ptr_nxt_s;
  logic [IDX_W-1:0]  old_ptr_r, old_ptr_nxt_s;
  logic [IDX_W-1:0]  rd_ptr_r, rd_ptr_nxt_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] rd_r, rd_nxt_s;
  logic              we_s;
  logic              re_s;
  logic              seq_r;
  logic [15:0]       lft_out_r;
  logic [15:0]       rght_out_r;

  logic [15:0] mem_l_r [DEPTH];
  logic [15:0] mem_r_r [DEPTH];

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == PTR_LAST_C) ? '0 : p + IDX_W'(1);
  endfunction

  // Next-state and datapath control.
  // rd_ptr tracks old_ptr + rd (mod DEPTH) incrementally, so no modulo adder
  // is needed; it is loaded with the post-write oldest slot on entry to READ.
  always_comb begin
    state_nxt_s   = state_r;
    new_ptr_nxt_s = new_ptr_r;
    old_ptr_nxt_s = old_ptr_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    cnt_nxt_s     = cnt_r;
    rd_nxt_s      = rd_r;
    we_s          = 1'b0;
    re_s          = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (wrt_smpl) begin
          we_s          = 1'b1;
          new_ptr_nxt_s = ptr_inc(new_ptr_r);
          cnt_nxt_s     = cnt_r + ADDR_W'(1);
          if (cnt_r == CNT_LAST_C) begin
            state_nxt_s  = ST_READ;
            rd_nxt_s     = '0;
            rd_ptr_nxt_s = old_ptr_r;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_IDLE: begin
        if (wrt_smpl) begin
          // new_ptr == old_ptr here: the write replaces the oldest sample.
          we_s          = 1'b1;
          new_ptr_nxt_s = ptr_inc(new_ptr_r);
          old_ptr_nxt_s = ptr_inc(old_ptr_r);
          rd_ptr_nxt_s  = ptr_inc(old_ptr_r);
          rd_nxt_s      = '0;
          state_nxt_s   = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        // rd == DEPTH is the trailing cycle that lets the last read land.
        if (rd_r == RD_LAST_C) begin
          state_nxt_s = ST_IDLE;
          rd_nxt_s    = '0;
        end else begin
          re_s         = 1'b1;
          rd_nxt_s     = rd_r + ADDR_W'(1);
          rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
      end
    endcase
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_FILL;
      new_ptr_r <= '0;
      old_ptr_r <= '0;
      rd_ptr_r  <= '0;
      cnt_r     <= '0;
      rd_r      <= '0;
      seq_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      new_ptr_r <= new_ptr_nxt_s;
      old_ptr_r <= old_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rd_r      <= rd_nxt_s;
      seq_r     <= (state_nxt_s == ST_READ);
    end
  end

  // Sample memories: synchronous write, contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_l_r[new_ptr_r] <= lft_smpl;
      mem_r_r[new_ptr_r] <= rght_smpl;
    end
  end

  // Registered read port; holds its value whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out_r  <= 16'd0;
      rght_out_r <= 16'd0;
    end else if (re_s) begin
      lft_out_r  <= mem_l_r[rd_ptr_r];
      rght_out_r <= mem_r_r[rd_ptr_r];
    end
  end

`ifdef CIRC_QUEUE_OVR_EN
  logic ovr_r;

  // Sticky overrun: a write strobe arriving during a replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_r <= 1'b0;
    end else if (wrt_smpl && (state_r == ST_READ)) begin
      ovr_r <= 1'b1;
    end
  end

  assign ovr = ovr_r;
`else
  assign ovr = 1'b0;
`endif

  assign lft_out    = lft_out_r;
  assign rght_out   = rght_out_r;
  assign sequencing = seq_r;

endmodule

// File: tb/tb_circ_smpl_queue.sv
// Scoreboard bench for circ_smpl_queue (DEPTH = 8). The stimulus side keeps a
// sample-history model and pushes each expected replay window into a queue;
// a negedge monitor pops and compares whenever the model says a replay
// sample is on the outputs, and otherwise checks that the outputs hold.
module tb_circ_smpl_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] lft_smpl = 16'd0;
  logic [15:0] rght_smpl = 16'd0;
  logic        wrt_smpl = 1'b0;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        sequencing;
  logic        ovr;

  circ_smpl_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .wrt_smpl   (wrt_smpl),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .sequencing (sequencing),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] sl[$];
  logic [15:0] sr[$];
  logic [15:0] el[$];
  logic [15:0] er[$];
  int          last_e  = -100;
  int          next_ok = 0;
  logic        exp_ovr = 1'b0;

  // Monitor state
  logic [15:0] hold_l = 16'd0;
  logic [15:0] hold_r = 16'd0;
  logic        in_win;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept/drop decision and window generation from sample history.
  task automatic model_write(input int w, input logic [15:0] l, input logic [15:0] r);
    if (w >= next_ok) begin
      sl.push_back(l);
      sr.push_back(r);
      if (sl.size() > DEPTH) begin
        void'(sl.pop_front());
        void'(sr.pop_front());
      end
      if (sl.size() == DEPTH) begin
        foreach (sl[i]) begin
          el.push_back(sl[i]);
          er.push_back(sr[i]);
        end
        last_e  = w;
        next_ok = w + DEPTH + 2;
      end
    end else begin
`ifdef CIRC_QUEUE_OVR_EN
      exp_ovr = 1'b1;
`else
      exp_ovr = 1'b0;
`endif
    end
  endtask

  // Called at posedge+1; leaves time at the next posedge+1.
  task automatic do_write(input logic [15:0] l, input logic [15:0] r);
    lft_smpl  = l;
    rght_smpl = r;
    wrt_smpl  = 1'b1;
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0;
    model_write(cyc, l, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sequencing", {31'd0, sequencing}, 0);
    check("rst_lft_out", $signed(lft_out), 0);
    check("rst_rght_out", $signed(rght_out), 0);
    check("rst_ovr", {31'd0, ovr}, 0);
    sl.delete();
    sr.delete();
    el.delete();
    er.delete();
    last_e  = -100;
    next_ok = 0;
    exp_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: sequencing, ovr and output data every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_l = 16'd0;
      hold_r = 16'd0;
      check("reset_sequencing", {31'd0, sequencing}, 0);
      check("reset_lft_out", $signed(lft_out), 0);
      check("reset_rght_out", $signed(rght_out), 0);
      check("reset_ovr", {31'd0, ovr}, 0);
    end else begin
      in_win = (cyc >= last_e) && (cyc <= last_e + DEPTH);
      check("sequencing", {31'd0, sequencing}, {31'd0, in_win});
      check("ovr", {31'd0, ovr}, {31'd0, exp_ovr});
      if (in_win && (cyc > last_e)) begin
        if (el.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: no expected sample queued (cycle %0d)", cyc);
        end else begin
          hold_l = el.pop_front();
          hold_r = er.pop_front();
        end
      end
      check("lft_out", $signed(lft_out), $signed(hold_l));
      check("rght_out", $signed(rght_out), $signed(hold_r));
    end
  end

  initial begin
    #3;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill: L=1..8, R=-1..-8, spaced 20 cycles
    for (int i = 1; i <= 8; i++) begin
      do_write(16'(i), 16'(-i));
      idle(19);
    end

    // Steady state across several pointer wraps: L=9..20
    for (int i = 9; i <= 20; i++) begin
      do_write(16'(i), 16'(-i));
      idle(19);
    end

    // Overrun: write at T+4 of a window is dropped
    do_write(16'd21, 16'(-21));
    idle(3);
    do_write(16'd99, 16'(-99));
    idle(20);
    do_write(16'd22, 16'(-22));
    idle(20);

    // Reset mid-window at T+5
    do_write(16'd23, 16'(-23));
    idle(4);
    do_reset();

    // Post-reset refill: 7 writes without a window, 8th starts one
    for (int i = 1; i <= 8; i++) begin
      do_write(16'(100 + i), 16'(-100 - i));
      idle(12);
    end

    // Back-to-back at the minimum spacing
    do_write(16'd200, 16'(-200));
    idle(DEPTH + 1);
    do_write(16'd201, 16'(-201));
    idle(DEPTH + 4);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 250; n++) begin
      idle($urandom_range(0, DEPTH + 4));
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end
      do_write(16'($urandom), 16'($urandom));
    end

    idle(DEPTH + 4);
    check("scoreboard_leftover", el.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
